// File: rtl/riscv_pkg.sv
// Shared register-file widths and types for the issue scoreboard.
package riscv_pkg;

    localparam int ADDR_W   = 6;
    localparam int CNT_W    = 2;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [CNT_W-1:0]  sb_cnt_t;

    localparam sb_cnt_t CNT_MAX = '1;

endpackage

// File: rtl/sb_entry.sv
// Pending-write counter for one architectural register.
module sb_entry
    import riscv_pkg::*;
(
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_busy,
    output logic o_full,
    output logic o_underflow
);

    sb_cnt_t cnt;

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            cnt <= '0;
        end else if (i_inc && !i_dec) begin
            cnt <= cnt + 1'b1;
        end else if (i_dec && !i_inc && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign o_busy      = (cnt != '0);
    assign o_full      = (cnt == CNT_MAX);
    // A retire paired with an issue to the same register is a net no-op, not an underflow.
    assign o_underflow = i_dec && !i_inc && (cnt == '0);

endmodule

// File: rtl/issue_scoreboard.sv
// RAW / WAW-limit hazard scoreboard gating decode issue against in-flight register writes.
module issue_scoreboard
    import riscv_pkg::*;
#(
    parameter int PERF_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_id_valid,
    output logic              o_id_ready,
    input  logic [ADDR_W-1:0] i_id_rs1,
    input  logic              i_id_rs1_en,
    input  logic [ADDR_W-1:0] i_id_rs2,
    input  logic              i_id_rs2_en,
    input  logic [ADDR_W-1:0] i_id_rd,
    input  logic              i_id_rd_we,
    input  logic              i_wb_valid,
    input  logic [ADDR_W-1:0] i_wb_rd,
    input  logic              i_flush,
    output logic [ADDR_W:0]   o_pending,
    output logic [PERF_W-1:0] o_stall_cnt,
    output logic              o_err
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] full;
    logic [NUM_REGS-1:0] underflow;

    logic clr;
    logic hazard_rs1, hazard_rs2, waw_full;
    logic issue, tracked_issue, retire_ok;

    assign clr = i_rst || i_flush;

    assign hazard_rs1 = i_id_rs1_en && (i_id_rs1 != '0) && busy[i_id_rs1];
    assign hazard_rs2 = i_id_rs2_en && (i_id_rs2 != '0) && busy[i_id_rs2];
    assign waw_full   = i_id_rd_we  && (i_id_rd  != '0) && full[i_id_rd];

    assign o_id_ready = !i_rst && !i_flush && !hazard_rs1 && !hazard_rs2 && !waw_full;

    assign issue         = i_id_valid && o_id_ready;
    assign tracked_issue = issue && i_id_rd_we && (i_id_rd != '0);
    // A retire only decrements the total when some counter actually moves or cancels an issue.
    assign retire_ok     = !clr && i_wb_valid && (i_wb_rd != '0) &&
                           (busy[i_wb_rd] || (tracked_issue && i_id_rd == i_wb_rd));

    // Register 0 is hardwired and never tracked.
    assign busy[0]      = 1'b0;
    assign full[0]      = 1'b0;
    assign underflow[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        sb_entry u_entry (
            .i_clk       (i_clk),
            .i_clr       (clr),
            .i_inc       (tracked_issue && (i_id_rd == reg_addr_t'(r))),
            .i_dec       (!clr && i_wb_valid && (i_wb_rd == reg_addr_t'(r))),
            .o_busy      (busy[r]),
            .o_full      (full[r]),
            .o_underflow (underflow[r])
        );
    end

    always_ff @(posedge i_clk) begin
        if (clr) begin
            o_pending <= '0;
        end else if (tracked_issue && !retire_ok) begin
            o_pending <= o_pending + 1'b1;
        end else if (retire_ok && !tracked_issue) begin
            o_pending <= o_pending - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_stall_cnt <= '0;
        end else if (i_id_valid && !o_id_ready && !i_flush && o_stall_cnt != '1) begin
            o_stall_cnt <= o_stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_err <= 1'b0;
        end else if (!i_flush && (|underflow)) begin
            o_err <= 1'b1;
        end
    end

endmodule
